ring_drain_tracker: RTL and testbench
=====================================

Name: ring_drain_tracker

Overview:
- Replaces the fixed-length "wait NUM_CELLS cycles" drain with an exact in-flight count of force packets on the ring interconnect.
- Collects per-PE reference-particle writeback completion, then counts packets injected into and ejected from the ring.
- Asserts drain-complete only when every PE has issued its writeback and the ring is provably empty.
- Sits between the PE array, the ring and broadcast_controller; drives all_ref_wb_issued and interconnect_empty.

Parameters:
NUM_CELLS, 64, number of PEs and ring nodes
INFLIGHT_WIDTH, 12, width of the in-flight packet counter
SETTLE_CYCLES, 2, consecutive idle cycles required before declaring the ring empty
STAT_WIDTH, 16, width of the drain-duration statistic

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-low reset
ref_wb_issued  in  NUM_CELLS  per-PE pulse: last reference writeback issued
inject_valid  in  NUM_CELLS  per-node packet_valid into the ring
inject_ready  in  NUM_CELLS  per-node ring ready
eject_valid  in  NUM_CELLS  per-node data_valid out of the ring (force cache write enable)
goto_next_ref  in  1  pulse from broadcast_controller: advance to next reference
iter_start  in  1  pulse: start of iteration
all_ref_wb_issued  out  1  all PEs have issued (high in DRAIN and DONE)
interconnect_empty  out  1  ring drained (high in DONE only)
inflight_count  out  INFLIGHT_WIDTH  current packets in ring
drain_cycles  out  STAT_WIDTH  cycles spent in last DRAIN
err_underflow  out  1  sticky: eject with no packet in flight
err_overflow  out  1  sticky: counter saturated high
err_early_wb  out  1  sticky: ref_wb_issued pulse outside COLLECT

Behaviour:
- Reset (rst=0, async): state=COLLECT; sticky vector=0; inflight=0; pipeline regs=0; all outputs 0.
- Stage 1 (registered): inj_r <= popcount(inject_valid & inject_ready); ej_r <= popcount(eject_valid). Width $clog2(NUM_CELLS+1).
- Stage 2: inflight <= inflight + inj_r - ej_r, computed at INFLIGHT_WIDTH+1 bits.
  - Result < 0: write 0 and set err_underflow.
  - Result > 2^INFLIGHT_WIDTH-1: saturate and set err_overflow.
  - The counter runs continuously in every state. Only reset clears it; iter_start does not.
- Latency: a handshake at cycle t is visible in inflight_count at t+2.
- idle = (inflight==0) & (inj_r==0) & (ej_r==0) & ~|(inject_valid&inject_ready) & ~|eject_valid.
- FSM:
  - COLLECT: sticky[k] <= sticky[k] | ref_wb_issued[k]. When registered &sticky==1, go to DRAIN next cycle. Clear the settle counter and drain_cycles accumulator.
  - DRAIN: all_ref_wb_issued=1. Accumulator increments each cycle and saturates at all-ones. settle_cnt increments while idle and resets to 0 on any non-idle cycle. When settle_cnt reaches SETTLE_CYCLES, go to DONE and latch the accumulator into drain_cycles.
  - DONE: all_ref_wb_issued=1, interconnect_empty=1. On goto_next_ref, go to COLLECT and clear sticky.
- goto_next_ref in DRAIN: honoured. Go to COLLECT, clear sticky, leave drain_cycles unchanged. The in-flight count carries over, so stragglers are still tracked.
- goto_next_ref in COLLECT: ignored.
- ref_wb_issued in DRAIN/DONE, including the cycle of goto_next_ref: dropped, and err_early_wb set.
- iter_start: synchronous, any state. Go to COLLECT and clear sticky and settle_cnt. Takes priority over goto_next_ref in the same cycle.
- Error flags are sticky until reset.
- Reset mid-DRAIN: immediate return to the reset state. In-flight accounting restarts at 0; the bench must also reset the ring.

Decomposition:
- Add to md_pkg:
  - drain_state_t enum {COLLECT, DRAIN, DONE}
  - localparam POPCNT_WIDTH = $clog2(NUM_CELLS+1)
- One sub-module, valid_popcount: registered popcount of a NUM_CELLS-bit vector with async active-low reset. Instantiated twice (inject, eject).

Test Plan:
(bench NUM_CELLS=4, SETTLE_CYCLES=2)
1. Reset held low, then released with no traffic -> all outputs 0, state COLLECT; pulses on ref_wb_issued[0..3] at cycles 1,3,3,5 -> all_ref_wb_issued rises at cycle 7. Ring never active, so interconnect_empty rises at cycle 9.
2. Inject 3 handshakes on cycle 10 (nodes 0,1,2), eject 1 each on cycles 14,15,16 -> inflight_count 3 at cycle 12, 0 at cycle 18. With sticky full, interconnect_empty rises at cycle 20 and drain_cycles reflects DRAIN duration.
3. inject_valid=1 with inject_ready=0 for 5 cycles -> inflight_count stays 0, no handshake counted.
4. eject_valid pulse with inflight=0 -> err_underflow=1, inflight_count stays 0; a later reset clears it.
5. goto_next_ref during DRAIN with inflight=2 -> state COLLECT, sticky cleared, inflight_count remains 2 until ejected.
6. ref_wb_issued[1] pulse while in DONE -> err_early_wb=1, sticky unaffected; iter_start and goto_next_ref in the same cycle -> COLLECT, with sticky cleared.

Source files
------------

// File: rtl/md_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | md_pkg                                                                   |
// | Shared types and constants for the ring drain tracker.                   |
// | Rev 1.0 - initial release                                                |
// ----------------------------------------------------------------------------
package md_pkg;

  // Drain tracker states
  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    DONE    = 2'd2
  } drain_state_t;

  // Default array size and the popcount width it implies
  localparam int DEF_NUM_CELLS = 64;
  localparam int POPCNT_WIDTH  = $clog2(DEF_NUM_CELLS + 1);

endpackage
`default_nettype wire

// File: rtl/valid_popcount.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | valid_popcount                                                           |
// | Registered population count of a per-node valid vector.                  |
// | Rev 1.0 - initial release                                                |
// ----------------------------------------------------------------------------
module valid_popcount
  import md_pkg::*;
#(
  parameter int NUM_BITS    = DEF_NUM_CELLS,
  parameter int COUNT_WIDTH = POPCNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_BITS-1:0]    bits,
  output logic [COUNT_WIDTH-1:0] count
);

  logic [COUNT_WIDTH-1:0] w_sum;
  logic [COUNT_WIDTH-1:0] r_count;

  // Sum of set bits in the current vector
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_BITS; i++) begin
      w_sum = w_sum + COUNT_WIDTH'(bits[i]);
    end
  end

  // Register the count so the wide adder tree gets a full cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_sum;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/ring_drain_tracker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | ring_drain_tracker                                                       |
// | Tracks reference writeback completion and exact ring occupancy, and      |
// | declares the drain complete once the ring is provably empty.             |
// | Rev 1.0 - initial release                                                |
// ----------------------------------------------------------------------------
module ring_drain_tracker
  import md_pkg::*;
#(
  parameter int NUM_CELLS      = DEF_NUM_CELLS,
  parameter int INFLIGHT_WIDTH = 12,
  parameter int SETTLE_CYCLES  = 2,
  parameter int STAT_WIDTH     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CELLS-1:0]      ref_wb_issued,
  input  logic [NUM_CELLS-1:0]      inject_valid,
  input  logic [NUM_CELLS-1:0]      inject_ready,
  input  logic [NUM_CELLS-1:0]      eject_valid,
  input  logic                      goto_next_ref,
  input  logic                      iter_start,
  output logic                      all_ref_wb_issued,
  output logic                      interconnect_empty,
  output logic [INFLIGHT_WIDTH-1:0] inflight_count,
  output logic [STAT_WIDTH-1:0]     drain_cycles,
  output logic                      err_underflow,
  output logic                      err_overflow,
  output logic                      err_early_wb
);

  localparam int c_CNT_W    = $clog2(NUM_CELLS + 1);
  localparam int c_SUM_W    = INFLIGHT_WIDTH + 1;
  localparam int c_SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [c_SETTLE_W-1:0] c_SETTLE_LAST = c_SETTLE_W'(SETTLE_CYCLES - 1);

  logic [NUM_CELLS-1:0]      w_handshake;
  logic [c_CNT_W-1:0]        r_inj;
  logic [c_CNT_W-1:0]        r_ej;
  logic [c_SUM_W-1:0]        w_sum;
  logic [c_SUM_W-1:0]        w_ej_ext;
  logic [c_SUM_W-1:0]        w_diff;
  logic [INFLIGHT_WIDTH-1:0] w_inflight_nxt;
  logic                      w_under;
  logic                      w_over;
  logic                      w_idle;
  logic [INFLIGHT_WIDTH-1:0] r_inflight;

  drain_state_t              r_state,  w_state_nxt;
  logic [NUM_CELLS-1:0]      r_sticky, w_sticky_nxt;
  logic [c_SETTLE_W-1:0]     r_settle, w_settle_nxt;
  logic [STAT_WIDTH-1:0]     r_acc,    w_acc_nxt;
  logic [STAT_WIDTH-1:0]     r_drain,  w_drain_nxt;
  logic [STAT_WIDTH-1:0]     w_acc_inc;
  logic                      w_early_wb;
  logic                      r_err_under, r_err_over, r_err_early;

  assign w_handshake = inject_valid & inject_ready;

  valid_popcount #(.NUM_BITS(NUM_CELLS), .COUNT_WIDTH(c_CNT_W)) u_inj_pop (
    .clk   (clk),
    .rst   (rst),
    .bits  (w_handshake),
    .count (r_inj)
  );

  valid_popcount #(.NUM_BITS(NUM_CELLS), .COUNT_WIDTH(c_CNT_W)) u_ej_pop (
    .clk   (clk),
    .rst   (rst),
    .bits  (eject_valid),
    .count (r_ej)
  );

  // One extra bit of headroom lets overflow show up as the top bit
  assign w_sum    = c_SUM_W'(r_inflight) + c_SUM_W'(r_inj);
  assign w_ej_ext = c_SUM_W'(r_ej);
  assign w_diff   = w_sum - w_ej_ext;

  // Clamp the in-flight update at zero and at all-ones, flagging either event
  always_comb begin
    w_under        = 1'b0;
    w_over         = 1'b0;
    w_inflight_nxt = w_diff[INFLIGHT_WIDTH-1:0];
    if (w_sum < w_ej_ext) begin
      w_under        = 1'b1;
      w_inflight_nxt = '0;
    end else if (w_diff[INFLIGHT_WIDTH]) begin
      w_over         = 1'b1;
      w_inflight_nxt = '1;
    end
  end

  // Empty means nothing counted, nothing in the popcount stage, nothing on the wires
  assign w_idle = (r_inflight == '0) && (r_inj == '0) && (r_ej == '0) &&
                  !(|w_handshake) && !(|eject_valid);

  assign w_acc_inc = (r_acc == '1) ? r_acc : r_acc + STAT_WIDTH'(1);

  // Next-state, sticky collection, settle counting and drain statistic
  always_comb begin
    w_state_nxt  = r_state;
    w_sticky_nxt = r_sticky;
    w_settle_nxt = r_settle;
    w_acc_nxt    = r_acc;
    w_drain_nxt  = r_drain;
    w_early_wb   = 1'b0;
    if (iter_start) begin
      w_state_nxt  = COLLECT;
      w_sticky_nxt = '0;
      w_settle_nxt = '0;
      w_early_wb   = (r_state != COLLECT) && (|ref_wb_issued);
    end else begin
      case (r_state)
        COLLECT: begin
          w_sticky_nxt = r_sticky | ref_wb_issued;
          w_settle_nxt = '0;
          w_acc_nxt    = '0;
          if (&r_sticky) begin
            w_state_nxt = DRAIN;
          end
        end
        DRAIN: begin
          w_early_wb   = |ref_wb_issued;
          w_acc_nxt    = w_acc_inc;
          w_settle_nxt = w_idle ? r_settle + c_SETTLE_W'(1) : '0;
          if (goto_next_ref) begin
            w_state_nxt  = COLLECT;
            w_sticky_nxt = '0;
          end else if (w_idle && (r_settle == c_SETTLE_LAST)) begin
            w_state_nxt = DONE;
            w_drain_nxt = w_acc_inc;
          end
        end
        DONE: begin
          w_early_wb = |ref_wb_issued;
          if (goto_next_ref) begin
            w_state_nxt  = COLLECT;
            w_sticky_nxt = '0;
          end
        end
        default: begin
          w_state_nxt  = COLLECT;
          w_sticky_nxt = '0;
        end
      endcase
    end
  end

  // State, counters and sticky error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= COLLECT;
      r_sticky    <= '0;
      r_settle    <= '0;
      r_acc       <= '0;
      r_drain     <= '0;
      r_inflight  <= '0;
      r_err_under <= 1'b0;
      r_err_over  <= 1'b0;
      r_err_early <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sticky    <= w_sticky_nxt;
      r_settle    <= w_settle_nxt;
      r_acc       <= w_acc_nxt;
      r_drain     <= w_drain_nxt;
      r_inflight  <= w_inflight_nxt;
      r_err_under <= r_err_under | w_under;
      r_err_over  <= r_err_over  | w_over;
      r_err_early <= r_err_early | w_early_wb;
    end
  end

  assign all_ref_wb_issued  = (r_state == DRAIN) || (r_state == DONE);
  assign interconnect_empty = (r_state == DONE);
  assign inflight_count     = r_inflight;
  assign drain_cycles       = r_drain;
  assign err_underflow      = r_err_under;
  assign err_overflow       = r_err_over;
  assign err_early_wb       = r_err_early;

endmodule
`default_nettype wire

// File: tb/tb_ring_drain_tracker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | tb_ring_drain_tracker                                                    |
// | Directed self-checking bench for ring_drain_tracker (4 cells, 3-bit      |
// | in-flight counter, 2 settle cycles).                                     |
// | Rev 1.0 - initial release                                                |
// ----------------------------------------------------------------------------
module tb_ring_drain_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ref_wb_issued;
  logic [3:0]  inject_valid;
  logic [3:0]  inject_ready;
  logic [3:0]  eject_valid;
  logic        goto_next_ref;
  logic        iter_start;
  logic        all_ref_wb_issued;
  logic        interconnect_empty;
  logic [2:0]  inflight_count;
  logic [15:0] drain_cycles;
  logic        err_underflow;
  logic        err_overflow;
  logic        err_early_wb;

  int checks = 0;
  int errors = 0;

  ring_drain_tracker #(
    .NUM_CELLS      (4),
    .INFLIGHT_WIDTH (3),
    .SETTLE_CYCLES  (2),
    .STAT_WIDTH     (16)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .ref_wb_issued      (ref_wb_issued),
    .inject_valid       (inject_valid),
    .inject_ready       (inject_ready),
    .eject_valid        (eject_valid),
    .goto_next_ref      (goto_next_ref),
    .iter_start         (iter_start),
    .all_ref_wb_issued  (all_ref_wb_issued),
    .interconnect_empty (interconnect_empty),
    .inflight_count     (inflight_count),
    .drain_cycles       (drain_cycles),
    .err_underflow      (err_underflow),
    .err_overflow       (err_overflow),
    .err_early_wb       (err_early_wb)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs are then driven and outputs sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; ref_wb_issued = '0; inject_valid = '0; inject_ready = '0;
    eject_valid = '0; goto_next_ref = 1'b0; iter_start = 1'b0;
    step(); step(); step();
    checks++;
    if ({all_ref_wb_issued, interconnect_empty, inflight_count, drain_cycles,
         err_underflow, err_overflow, err_early_wb} !== 25'd0) begin
      errors++; $display("FAIL reset_outputs got %b want all zero",
        {all_ref_wb_issued, interconnect_empty, inflight_count, drain_cycles,
         err_underflow, err_overflow, err_early_wb});
    end
    rst = 1'b1;                                   // cycle 0
    step(); ref_wb_issued = 4'b0001;              // cycle 1
    checks++;
    if (all_ref_wb_issued !== 1'b0) begin
      errors++; $display("FAIL collect_after_reset got %b want 0", all_ref_wb_issued);
    end
    step(); ref_wb_issued = 4'b0000;              // cycle 2
    step(); ref_wb_issued = 4'b0110;              // cycle 3
    step(); ref_wb_issued = 4'b0000;              // cycle 4
    step(); ref_wb_issued = 4'b1000;              // cycle 5
    step(); ref_wb_issued = 4'b0000;              // cycle 6
    checks++;
    if (all_ref_wb_issued !== 1'b0) begin
      errors++; $display("FAIL all_wb_cycle6 got %b want 0", all_ref_wb_issued);
    end
    step();                                       // cycle 7
    checks++;
    if ({all_ref_wb_issued, interconnect_empty} !== 2'b10) begin
      errors++; $display("FAIL drain_entry_cycle7 got %b want 10", {all_ref_wb_issued, interconnect_empty});
    end
    step();                                       // cycle 8
    checks++;
    if (interconnect_empty !== 1'b0) begin
      errors++; $display("FAIL empty_cycle8 got %b want 0", interconnect_empty);
    end
    step();                                       // cycle 9
    checks++;
    if ({all_ref_wb_issued, interconnect_empty} !== 2'b11) begin
      errors++; $display("FAIL done_cycle9 got %b want 11", {all_ref_wb_issued, interconnect_empty});
    end
    checks++;
    if (drain_cycles !== 16'd2) begin
      errors++; $display("FAIL drain_cycles_idle got %0d want 2", drain_cycles);
    end
  endtask

  task automatic test_drain_traffic();
    iter_start = 1'b1;
    step(); iter_start = 1'b0;                    // A+1: COLLECT
    checks++;
    if ({all_ref_wb_issued, interconnect_empty} !== 2'b00) begin
      errors++; $display("FAIL iter_start_collect got %b want 00", {all_ref_wb_issued, interconnect_empty});
    end
    checks++;
    if (drain_cycles !== 16'd2) begin
      errors++; $display("FAIL drain_cycles_held got %0d want 2", drain_cycles);
    end
    ref_wb_issued = 4'hF;
    step(); ref_wb_issued = 4'h0;                 // A+2
    step();                                       // T: DRAIN
    checks++;
    if (all_ref_wb_issued !== 1'b1) begin
      errors++; $display("FAIL drain_entry_t got %b want 1", all_ref_wb_issued);
    end
    inject_valid = 4'b0111; inject_ready = 4'hF;
    step(); inject_valid = 4'b0000;               // T+1
    step();                                       // T+2
    checks++;
    if (inflight_count !== 3'd3) begin
      errors++; $display("FAIL inflight_after_inject got %0d want 3", inflight_count);
    end
    step(); step();                               // T+4
    eject_valid = 4'b0001;
    step(); eject_valid = 4'b0010;                // T+5
    step(); eject_valid = 4'b0100;                // T+6
    checks++;
    if (inflight_count !== 3'd2) begin
      errors++; $display("FAIL inflight_first_eject got %0d want 2", inflight_count);
    end
    step(); eject_valid = 4'b0000;                // T+7
    checks++;
    if (inflight_count !== 3'd1) begin
      errors++; $display("FAIL inflight_second_eject got %0d want 1", inflight_count);
    end
    step();                                       // T+8
    checks++;
    if ({inflight_count, interconnect_empty} !== 4'b0000) begin
      errors++; $display("FAIL drained_not_settled got %b want 0000", {inflight_count, interconnect_empty});
    end
    step();                                       // T+9
    checks++;
    if (interconnect_empty !== 1'b0) begin
      errors++; $display("FAIL settle_first_idle got %b want 0", interconnect_empty);
    end
    step();                                       // T+10
    checks++;
    if (interconnect_empty !== 1'b1) begin
      errors++; $display("FAIL empty_after_settle got %b want 1", interconnect_empty);
    end
    checks++;
    if (drain_cycles !== 16'd10) begin
      errors++; $display("FAIL drain_cycles_traffic got %0d want 10", drain_cycles);
    end
  endtask

  task automatic test_no_handshake();
    inject_valid = 4'hF; inject_ready = 4'h0;
    for (int i = 0; i < 7; i++) begin
      if (i == 5) inject_valid = 4'h0;
      step();
      checks++;
      if (inflight_count !== 3'd0) begin
        errors++; $display("FAIL no_handshake_step%0d got %0d want 0", i, inflight_count);
      end
    end
    inject_ready = 4'hF;
  endtask

  task automatic test_underflow();
    eject_valid = 4'b0001;
    step(); eject_valid = 4'b0000;
    step();
    checks++;
    if ({err_underflow, inflight_count} !== 4'b1000) begin
      errors++; $display("FAIL underflow_flag got %b want 1000", {err_underflow, inflight_count});
    end
    step();
    checks++;
    if (err_underflow !== 1'b1) begin
      errors++; $display("FAIL underflow_sticky got %b want 1", err_underflow);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({err_underflow, interconnect_empty, all_ref_wb_issued} !== 3'b000) begin
      errors++; $display("FAIL underflow_reset got %b want 000", {err_underflow, interconnect_empty, all_ref_wb_issued});
    end
    rst = 1'b1;
  endtask

  task automatic test_goto_drain();
    ref_wb_issued = 4'hF;
    step(); ref_wb_issued = 4'h0;                 // B+1
    step();                                       // B+2: DRAIN
    inject_valid = 4'b0011;
    step(); inject_valid = 4'b0000;               // B+3
    step();                                       // B+4
    checks++;
    if ({all_ref_wb_issued, inflight_count} !== 4'b1010) begin
      errors++; $display("FAIL goto_pre_state got %b want 1010", {all_ref_wb_issued, inflight_count});
    end
    goto_next_ref = 1'b1;
    step(); goto_next_ref = 1'b0;                 // B+5
    checks++;
    if ({all_ref_wb_issued, inflight_count} !== 4'b0010) begin
      errors++; $display("FAIL goto_in_drain got %b want 0010", {all_ref_wb_issued, inflight_count});
    end
    ref_wb_issued = 4'b0111;
    step(); ref_wb_issued = 4'b0000;
    step(); step();                               // B+8
    checks++;
    if ({all_ref_wb_issued, inflight_count} !== 4'b0010) begin
      errors++; $display("FAIL goto_sticky_cleared got %b want 0010", {all_ref_wb_issued, inflight_count});
    end
    eject_valid = 4'b0011;
    step(); eject_valid = 4'b0000;
    step();                                       // B+10
    checks++;
    if ({inflight_count, err_underflow} !== 4'b0000) begin
      errors++; $display("FAIL straggler_eject got %b want 0000", {inflight_count, err_underflow});
    end
    ref_wb_issued = 4'b1000;
    step(); ref_wb_issued = 4'b0000;              // C+1
    step();                                       // C+2
    checks++;
    if ({all_ref_wb_issued, interconnect_empty} !== 2'b10) begin
      errors++; $display("FAIL redrain_entry got %b want 10", {all_ref_wb_issued, interconnect_empty});
    end
    step(); step();                               // C+4
    checks++;
    if ({interconnect_empty, drain_cycles} !== {1'b1, 16'd2}) begin
      errors++; $display("FAIL redrain_done got %b/%0d want 1/2", interconnect_empty, drain_cycles);
    end
  endtask

  task automatic test_early_wb();
    ref_wb_issued = 4'b0010;
    step(); ref_wb_issued = 4'b0000;              // D+1
    checks++;
    if ({err_early_wb, interconnect_empty} !== 2'b11) begin
      errors++; $display("FAIL early_wb_flag got %b want 11", {err_early_wb, interconnect_empty});
    end
    iter_start = 1'b1; goto_next_ref = 1'b1;
    step(); iter_start = 1'b0; goto_next_ref = 1'b0;  // D+2
    checks++;
    if ({all_ref_wb_issued, interconnect_empty} !== 2'b00) begin
      errors++; $display("FAIL iter_and_goto got %b want 00", {all_ref_wb_issued, interconnect_empty});
    end
    ref_wb_issued = 4'b1101;
    step(); ref_wb_issued = 4'b0000;
    step(); step();                               // D+5
    checks++;
    if (all_ref_wb_issued !== 1'b0) begin
      errors++; $display("FAIL early_sticky_cleared got %b want 0", all_ref_wb_issued);
    end
    ref_wb_issued = 4'b0010;
    step(); ref_wb_issued = 4'b0000;
    step();
    checks++;
    if ({all_ref_wb_issued, err_early_wb} !== 2'b11) begin
      errors++; $display("FAIL early_complete_drain got %b want 11", {all_ref_wb_issued, err_early_wb});
    end
  endtask

  task automatic test_overflow();
    inject_valid = 4'hF; inject_ready = 4'hF;
    step(); step(); inject_valid = 4'h0;          // E+2
    checks++;
    if ({inflight_count, err_overflow} !== 4'b1000) begin
      errors++; $display("FAIL overflow_pre got %b want 1000", {inflight_count, err_overflow});
    end
    step();                                       // E+3
    checks++;
    if ({inflight_count, err_overflow} !== 4'b1111) begin
      errors++; $display("FAIL overflow_saturate got %b want 1111", {inflight_count, err_overflow});
    end
    step();
    checks++;
    if ({inflight_count, err_overflow} !== 4'b1111) begin
      errors++; $display("FAIL overflow_hold got %b want 1111", {inflight_count, err_overflow});
    end
  endtask

  initial begin
    test_reset();
    test_drain_traffic();
    test_no_handshake();
    test_underflow();
    test_goto_drain();
    test_early_wb();
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a stalled run
  initial begin
    #50000;
    $display("FAIL timeout reached without finishing");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
